// File: rtl/mpy_pkg.sv
// mpy_pkg: shared state encoding and default operand width for the shared multiplier
package mpy_pkg;
   localparam int W_DEF = 4;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/mpy_step_dp.sv
// mpy_step_dp: one shift-and-add step of a signed Baugh-free multiply; the sign bit's weight is subtracted
module mpy_step_dp
   import mpy_pkg::*;
#(
   parameter int W  = W_DEF,
   parameter int SW = (W > 1) ? $clog2(W) : 1
) (
   input  logic [2*W-1:0] acc,
   input  logic [W-1:0]   a,
   input  logic           b,
   input  logic [SW-1:0]  step,
   input  logic           last,
   output logic [2*W-1:0] nxt
);
   logic [2*W-1:0] term;
   always_comb begin
      term = b ? ({{W{a[W-1]}}, a} << step) : '0;
      nxt  = last ? acc - term : acc + term;
   end
endmodule

// File: rtl/mpy_share_ctrl.sv
// mpy_share_ctrl: round-robin sharing of one sequential signed multiplier between two requesters
module mpy_share_ctrl
   import mpy_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req0,
   input  logic           req1,
   input  logic [W-1:0]   a0,
   input  logic [W-1:0]   b0,
   input  logic [W-1:0]   a1,
   input  logic [W-1:0]   b1,
   output logic           ack0,
   output logic           ack1,
   output logic           busy,
   output logic           resp_valid,
   output logic           resp_id,
   output logic [2*W-1:0] product,
   input  logic           resp_ready
);
   localparam int SW = (W > 1) ? $clog2(W) : 1;
   state_t         state, nxt;
   logic           ptr, g1, last;
   logic [W-1:0]   a_r, b_r;
   logic [SW-1:0]  step;
   logic [2*W-1:0] acc, acc_nxt;
   mpy_step_dp #(.W(W), .SW(SW)) u_dp (
      .acc (acc),
      .a   (a_r),
      .b   (b_r[step]),
      .step(step),
      .last(last),
      .nxt (acc_nxt)
   );
   // ptr holds the last-served requester; requester 1 wins a tie only when 0 was served last
   always_comb begin
      g1         = req1 & (~req0 | ~ptr);
      last       = step == SW'(W - 1);
      ack0       = (state == IDLE) & ~rst & req0 & ~g1;
      ack1       = (state == IDLE) & ~rst & g1;
      busy       = ~rst & (state != IDLE);
      resp_valid = ~rst & (state == DONE);
      nxt        = (state == IDLE) ? ((req0 | req1) ? CALC : IDLE) :
                   (state == CALC) ? (last ? DONE : CALC) :
                   (resp_ready ? IDLE : DONE);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         acc     <= '0;
         step    <= '0;
         product <= '0;
         resp_id <= 1'b0;
         ptr     <= 1'b1;
         a_r     <= '0;
         b_r     <= '0;
      end else begin
         state <= nxt;
         if (ack0 | ack1) begin
            a_r     <= ack1 ? a1 : a0;
            b_r     <= ack1 ? b1 : b0;
            resp_id <= ack1;
            ptr     <= ack1;
            acc     <= '0;
            step    <= '0;
         end
         if (state == CALC) begin
            acc  <= acc_nxt;
            step <= step + 1'b1;
            if (last) product <= acc_nxt;
         end
      end
   end
endmodule

// File: tb/tb_mpy_share_ctrl.sv
// tb_mpy_share_ctrl: directed vector table plus arbitration, backpressure, reset and exhaustive sequences
module tb_mpy_share_ctrl;
   localparam int W = 4;
   logic           clk = 1'b0;
   logic           rst, req0, req1, resp_ready;
   logic [W-1:0]   a0, b0, a1, b1;
   logic           ack0, ack1, busy, resp_valid, resp_id;
   logic [2*W-1:0] product;
   int             tests = 0, failed = 0;

   typedef struct {
      logic       r0, r1;
      logic [3:0] a0, b0, a1, b1;
      logic       id;
      logic [7:0] p;
   } vec_t;
   vec_t tv[8];

   mpy_share_ctrl #(.W(W)) dut (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .ack0(ack0), .ack1(ack1), .busy(busy),
      .resp_valid(resp_valid), .resp_id(resp_id), .product(product),
      .resp_ready(resp_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s got=%0h exp=%0h", n, got, exp);
      end
   endtask

   task automatic wait_ack(output bit ok);
      ok = 0;
      for (int n = 0; n < 20 && !ok; n++) begin
         @(negedge clk);
         if (ack0 | ack1) ok = 1;
         else begin @(posedge clk); #1; end
      end
      chk("ack_timeout", ok, 1);
   endtask

   task automatic wait_valid(output bit ok, output int lat);
      ok = 0;
      lat = 1;
      for (int n = 0; n < 20 && !ok; n++) begin
         @(negedge clk);
         if (resp_valid) ok = 1;
         else begin lat++; @(posedge clk); #1; end
      end
      chk("valid_timeout", ok, 1);
   endtask

   task automatic txn(input vec_t v);
      bit ok;
      int lat;
      @(posedge clk); #1;
      req0 = v.r0; a0 = v.a0; b0 = v.b0;
      req1 = v.r1; a1 = v.a1; b1 = v.b1;
      resp_ready = 1;
      wait_ack(ok);
      chk("ack_id", ack1, v.id);
      chk("ack_excl", ack0 & ack1, 0);
      @(posedge clk); #1;
      req0 = 0; req1 = 0;
      wait_valid(ok, lat);
      chk("latency", lat, W + 1);
      chk("product", product, v.p);
      chk("resp_id", resp_id, v.id);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok, seen;
      int lat, ack_cnt, resp_cnt, last_cyc, cyc;
      logic exp_id;
      vec_t v;
      logic signed [3:0] sa, sb;
      int pr;
      tv[0] = '{1, 0, 4'd3,  4'd5,  4'd0,  4'd0,  0, 8'h0F};
      tv[1] = '{1, 0, 4'h8,  4'h8,  4'd0,  4'd0,  0, 8'h40};
      tv[2] = '{0, 1, 4'd0,  4'd0,  4'h8,  4'd7,  1, 8'hC8};
      tv[3] = '{1, 0, 4'hF,  4'hF,  4'd0,  4'd0,  0, 8'h01};
      tv[4] = '{0, 1, 4'd0,  4'd0,  4'd7,  4'd7,  1, 8'h31};
      tv[5] = '{1, 0, 4'd0,  4'h8,  4'd0,  4'd0,  0, 8'h00};
      tv[6] = '{1, 1, 4'd2,  4'd3,  4'hD,  4'd2,  1, 8'hFA};
      tv[7] = '{1, 1, 4'hC,  4'd5,  4'd1,  4'd1,  0, 8'hEC};
      rst = 1; req0 = 1; req1 = 1; resp_ready = 0;
      a0 = 4'd1; b0 = 4'd1; a1 = 4'd1; b1 = 4'd1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ack0", ack0, 0);
      chk("rst_ack1", ack1, 0);
      chk("rst_busy", busy, 0);
      chk("rst_valid", resp_valid, 0);
      chk("rst_product", product, 0);
      chk("rst_id", resp_id, 0);
      @(posedge clk); #1;
      rst = 0; req0 = 0; req1 = 0;
      for (int i = 0; i < 8; i++) txn(tv[i]);

      // contention: last served was 0, so requester 1 leads
      @(posedge clk); #1;
      req0 = 1; a0 = 4'd2; b0 = 4'hD;
      req1 = 1; a1 = 4'd5; b1 = 4'h9;
      resp_ready = 1;
      ack_cnt = 0; resp_cnt = 0; last_cyc = 0;
      for (cyc = 0; cyc < 60 && resp_cnt < 4; cyc++) begin
         @(negedge clk);
         if (ack0 | ack1) begin
            exp_id = (ack_cnt % 2 == 0);
            chk("cont_ack_id", ack1, exp_id);
            chk("cont_excl", ack0 & ack1, 0);
            if (ack_cnt > 0) chk("cont_spacing", cyc - last_cyc, 6);
            last_cyc = cyc;
            ack_cnt++;
         end
         if (resp_valid) begin
            exp_id = (resp_cnt % 2 == 0);
            chk("cont_resp_id", resp_id, exp_id);
            chk("cont_product", product, exp_id ? 8'hDD : 8'hFA);
            resp_cnt++;
         end
         @(posedge clk); #1;
      end
      req0 = 0; req1 = 0;
      chk("cont_resp_cnt", resp_cnt, 4);

      // backpressure with requester 1 waiting
      @(posedge clk); #1;
      req0 = 1; a0 = 4'hB; b0 = 4'd3; resp_ready = 0;
      wait_ack(ok);
      chk("bp_ack0", ack0, 1);
      @(posedge clk); #1;
      req0 = 0; req1 = 1; a1 = 4'd6; b1 = 4'd2;
      wait_valid(ok, lat);
      for (int i = 0; i < 10; i++) begin
         if (i > 0) begin @(posedge clk); #1; @(negedge clk); end
         chk("bp_valid", resp_valid, 1);
         chk("bp_product", product, 8'hF1);
         chk("bp_id", resp_id, 0);
         chk("bp_noack", ack0 | ack1, 0);
      end
      @(posedge clk); #1;
      resp_ready = 1;
      @(negedge clk);
      chk("bp_hs_valid", resp_valid, 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_idle_busy", busy, 0);
      chk("bp_idle_valid", resp_valid, 0);
      chk("bp_next_ack1", ack1, 1);
      @(posedge clk); #1;
      req1 = 0;
      wait_valid(ok, lat);
      chk("bp2_product", product, 8'h0C);
      chk("bp2_id", resp_id, 1);

      // reset at CALC step 2 discards the op and restores the tie pointer
      @(posedge clk); #1;
      req0 = 1; req1 = 1; a0 = 4'd3; b0 = 4'd3;
      wait_ack(ok);
      chk("rc_ack0", ack0, 1);
      @(posedge clk); #1;
      req0 = 0; req1 = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1;
      @(negedge clk);
      chk("rc_busy", busy, 0);
      chk("rc_valid", resp_valid, 0);
      @(posedge clk); #1;
      rst = 0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (resp_valid) seen = 1;
         @(posedge clk); #1;
      end
      chk("rc_no_resp", seen, 0);
      req0 = 1; req1 = 1; a0 = 4'd2; b0 = 4'd2; a1 = 4'd7; b1 = 4'd7;
      wait_ack(ok);
      chk("rc_tie_ack0", ack0, 1);
      chk("rc_tie_ack1", ack1, 0);
      @(posedge clk); #1;
      req0 = 0; req1 = 0;
      wait_valid(ok, lat);
      chk("rc_product", product, 8'h04);
      chk("rc_id", resp_id, 0);

      // exhaustive operand sweep against a signed reference
      for (int i = 0; i < 256; i++) begin
         sa = 4'(i >> 4);
         sb = 4'(i);
         pr = sa * sb;
         v.r0 = (i % 2 == 0);
         v.r1 = (i % 2 == 1);
         v.a0 = sa; v.b0 = sb; v.a1 = sa; v.b1 = sb;
         v.id = (i % 2 == 1);
         v.p  = 8'(pr);
         txn(v);
      end
      @(posedge clk); #1;
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule

// File: doc/mpy_share_ctrl.md
MPY_SHARE_CTRL -- requirements
Module: mpy_share_ctrl

Interface
REQ-001 SHALL have parameter W, default 4, operand width in bits (signed two's complement); product width is 2W.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req0, req1  input  1  per-requester multiply request; held high until acked.
REQ-005 SHALL have ports a0, b0, a1, b1  input  W  signed operands of requester 0 and 1.
REQ-006 SHALL have ports ack0, ack1  output  1  one-cycle pulse; operands of that requester are captured at this cycle's edge.
REQ-007 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-008 SHALL have port resp_valid  output  1  product available.
REQ-009 SHALL have port resp_id  output  1  index of the requester that owns product.
REQ-010 SHALL have port product  output  2W  signed a*b of the served request.
REQ-011 SHALL have port resp_ready  input  1  consumer accepts product.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 IDLE: if req0 or req1 is high, SHALL assert exactly one ack (combinational, same cycle), capture that requester's a/b and id, clear accumulator and step counter, and go to CALC.
REQ-014 Arbitration SHALL be round-robin: a single requester is granted directly; with both high, the requester not served last is granted; last-served pointer resets to 1 (requester 0 wins first tie).
REQ-015 CALC SHALL take exactly W cycles, step i = 0..W-1: for i < W-1, acc += b[i] ? sext(a) << i : 0; for i = W-1, acc -= b[W-1] ? sext(a) << (W-1) : 0; all arithmetic modulo 2^(2W).
REQ-016 After step W-1, SHALL go to DONE. resp_valid first rises W+1 cycles after the ack cycle (W=4: 5 cycles).
REQ-017 DONE: resp_valid=1, and product/resp_id SHALL be held stable until resp_valid & resp_ready at an edge, then go to IDLE.
REQ-018 No ack SHALL be issued outside IDLE, so the next grant is at the earliest the cycle after the response handshake. A req held during CALC/DONE waits, and req/operand changes while busy SHALL have no effect.
REQ-019 resp_ready while not in DONE SHALL be ignored.
REQ-020 product SHALL equal the exact signed product for all operand pairs, including (-2^(W-1))*(-2^(W-1)) = +2^(2W-2).
REQ-021 ack0 and ack1 SHALL never be high in the same cycle.

Reset
REQ-022 On rst at an edge: state=IDLE, acc=0, step counter=0, product=0, resp_id=0, last-served pointer=1.
REQ-023 During the rst cycle, ack0=ack1=0, busy=0 and resp_valid=0.
REQ-024 Reset mid-CALC or mid-DONE SHALL discard the operation without producing a response; the requester must re-request.

Structure
REQ-025 Shared package mpy_pkg SHALL hold the state enumeration and the default width constant.
REQ-026 The per-step shift/add/subtract datapath SHALL be one sub-module, mpy_step_dp (inputs acc, a, b bit, step index, last flag; output next acc).
REQ-027 FSM, arbiter pointer and operand/result registers SHALL reside in mpy_share_ctrl.

Verification
REQ-028 Single request: req0, a0=3, b0=5 -> ack0 in cycle 0, resp_valid at cycle 5, product=0x0F, resp_id=0.
REQ-029 Sign corners: (-8)*(-8) -> 0x40; (-8)*7 -> 0xC8; (-1)*(-1) -> 0x01; 7*7 -> 0x31; 0*(-8) -> 0x00.
REQ-030 Contention: req0 and req1 both held continuously with resp_ready=1 -> acks alternate 0,1,0,1; each product is tagged with the correct resp_id; consecutive ack cycles are 6 cycles apart.
REQ-031 Backpressure: resp_ready=0 for 10 cycles in DONE -> product, resp_id and resp_valid stay stable and no ack is issued; resp_ready=1 -> IDLE next cycle.
REQ-032 Reset mid-CALC: rst at step 2 -> resp_valid never rises for that op; a re-request after reset is served as requester 0 first on a tie.
REQ-033 Exhaustive: all 256 (a, b) pairs at W=4 via alternating requesters -> every product matches a signed reference model.
